// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
//   Shared definitions for the parking-lot occupancy counter.
//   - status_t    : lot state encoding (EMPTY / PARTIAL / FULL)
//   - CAP_DEFAULT : default maximum occupancy
//   - CW_DEFAULT  : default count width (2**CW_DEFAULT > CAP_DEFAULT)
// ---------------------------------------------------------------------------
package parking_pkg;

    localparam int CAP_DEFAULT = 25;
    localparam int CW_DEFAULT  = 7;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } status_t;

endpackage

// File: rtl/bcd_split.sv
// ---------------------------------------------------------------------------
// bcd_split
//   Combinational binary-to-BCD split of a count in the range 0..99.
//   Ports:
//     i_value : CW-bit binary value (0..99)
//     o_tens  : BCD tens digit  (i_value / 10)
//     o_ones  : BCD ones digit  (i_value % 10)
// ---------------------------------------------------------------------------
module bcd_split #(
    parameter int CW = 7
) (
    input  logic [CW-1:0] i_value,
    output logic [3:0]    o_tens,
    output logic [3:0]    o_ones
);

    // Widen to at least 8 bits so the constant divisor 10 fits for small CW.
    localparam int EW = (CW > 8) ? CW : 8;

    logic [EW-1:0] w_ext;

    assign w_ext  = EW'(i_value);

    // Quotient and remainder are both below 10 for values 0..99, so
    // truncation to 4 bits is lossless.
    assign o_tens = 4'(w_ext / EW'(10));
    assign o_ones = 4'(w_ext % EW'(10));

endmodule

// File: rtl/parking_counter.sv
// ---------------------------------------------------------------------------
// parking_counter
//   Occupancy counter for a parking lot with a status FSM, sticky
//   overflow/underflow flags and registered BCD digits of the count.
//   Ports:
//     clk     : single clock, rising edge
//     reset   : asynchronous active-low reset
//     enter   : one-cycle pulse, one car entered
//     exit    : one-cycle pulse, one car left
//     clear   : synchronous clear of count and error flags (highest priority)
//     count   : registered occupancy
//     status  : registered lot state (EMPTY / PARTIAL / FULL)
//     full    : status == FULL
//     empty   : status == EMPTY
//     ovf_err : sticky, enter rejected while full
//     unf_err : sticky, exit rejected while empty
//     tens    : registered BCD tens digit of count
//     ones    : registered BCD ones digit of count
// ---------------------------------------------------------------------------
module parking_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = CAP_DEFAULT,
    parameter int CW       = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter,
    input  logic          exit,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic [1:0]    status,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err,
    output logic [3:0]    tens,
    output logic [3:0]    ones
);

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    status_t       r_status;
    status_t       w_status_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          r_unf;
    logic          w_unf_nxt;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic [3:0]    w_tens_nxt;
    logic [3:0]    w_ones_nxt;

    // -----------------------------------------------------------------------
    // Next count and error flags. Simultaneous enter/exit cancel out and
    // never raise an error, even at the empty or full boundary.
    // -----------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        if (clear) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
        end else if (enter && !exit) begin
            if (r_count == CAP) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + CW'(1);
            end
        end else if (exit && !enter) begin
            if (r_count == '0) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count - CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status FSM next state, derived from the next count so that status
    // lands in the same cycle as the count it describes. With CAPACITY == 1
    // the PARTIAL branch is never taken.
    // -----------------------------------------------------------------------
    always_comb begin
        w_status_nxt = r_status;
        if (w_count_nxt == '0) begin
            w_status_nxt = EMPTY;
        end else if (w_count_nxt == CAP) begin
            w_status_nxt = FULL;
        end else begin
            w_status_nxt = PARTIAL;
        end
    end

    // Digits are computed from the next count and registered alongside it.
    bcd_split #(
        .CW (CW)
    ) u_bcd_split (
        .i_value (w_count_nxt),
        .o_tens  (w_tens_nxt),
        .o_ones  (w_ones_nxt)
    );

    // Status FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status <= EMPTY;
        end else begin
            r_status <= w_status_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
        end
    end

    assign count   = r_count;
    assign status  = r_status;
    assign full    = (r_status == FULL);
    assign empty   = (r_status == EMPTY);
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;
    assign tens    = r_tens;
    assign ones    = r_ones;

endmodule

// File: doc/parking_counter.md
PARKING_COUNTER -- requirements
Module: parking_counter

Interface
REQ-001 Parameter CAPACITY, default 25, maximum lot occupancy (1..99).
REQ-002 Parameter CW, default 7, count width; SHALL satisfy 2**CW > CAPACITY.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enter  input  1  one-cycle pulse from car-detection stage: one car entered.
REQ-006 exit  input  1  one-cycle pulse from car-detection stage: one car left.
REQ-007 clear  input  1  synchronous clear of count and error flags.
REQ-008 count  output  CW  registered current occupancy.
REQ-009 status  output  2  registered lot state: EMPTY, PARTIAL or FULL.
REQ-010 full  output  1  high iff status == FULL.
REQ-011 empty  output  1  high iff status == EMPTY.
REQ-012 ovf_err  output  1  sticky: enter rejected while full.
REQ-013 unf_err  output  1  sticky: exit rejected while empty.
REQ-014 tens  output  4  registered BCD tens digit of count.
REQ-015 ones  output  4  registered BCD ones digit of count.

Function
REQ-016 Count SHALL update on the clock edge where the pulse is sampled; count, status, tens and ones SHALL all reflect the new value 1 cycle after the pulse, mutually consistent in every cycle.
REQ-017 enter only, count < CAPACITY: count +1.
REQ-018 exit only, count > 0: count -1.
REQ-019 enter and exit in the same cycle: count unchanged, no error set, including at count == 0 and count == CAPACITY.
REQ-020 enter only at count == CAPACITY: count holds; ovf_err set to 1 next cycle.
REQ-021 exit only at count == 0: count holds; unf_err set to 1 next cycle.
REQ-022 ovf_err and unf_err SHALL stay set until clear or reset; later legal traffic SHALL NOT clear them.
REQ-023 clear SHALL take priority over enter/exit: next cycle count = 0, status = EMPTY, both errors = 0, digits = 0.
REQ-024 Status FSM: EMPTY (count 0), PARTIAL (0 < count < CAPACITY), FULL (count == CAPACITY); the next state SHALL be computed from the next count, not the current one.
REQ-025 Transitions: EMPTY->PARTIAL on enter; PARTIAL->FULL on enter at CAPACITY-1; FULL->PARTIAL on exit; PARTIAL->EMPTY on exit at count 1; all states->EMPTY on clear.
REQ-026 With CAPACITY == 1, EMPTY<->FULL SHALL transition directly and PARTIAL SHALL be unreachable.
REQ-027 tens = count / 10 and ones = count % 10, each in 0..9, registered in the same cycle as count.
REQ-028 Inputs SHALL be treated as already synchronous single-cycle pulses. A pulse held high for N cycles SHALL count N times.

Reset
REQ-029 While reset is low: count = 0, status = EMPTY, full = 0, empty = 1, ovf_err = 0, unf_err = 0, tens = 0, ones = 0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard any pulse sampled in the same cycle. The first count change SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package parking_pkg SHALL hold the status_t enum (EMPTY=2'd0, PARTIAL=2'd1, FULL=2'd2), CAP_DEFAULT = 25 and CW_DEFAULT = 7.
REQ-032 Binary-to-BCD conversion SHALL be a separate combinational sub-module bcd_split (input CW-bit value, outputs tens, ones). Its outputs SHALL be registered in parking_counter.

Verification
REQ-033 Reset low, then release, then 3 enter pulses -> count 0,1,2,3 on successive cycles; status PARTIAL; tens 0, ones 3.
REQ-034 25 enters from 0, then 1 more enter -> count 25, full = 1, tens 2, ones 5; extra enter: count stays 25, ovf_err = 1.
REQ-035 exit at count 0 -> count stays 0, unf_err = 1, empty = 1. Then 1 enter -> count 1, unf_err still 1.
REQ-036 enter and exit together at count 25, at count 0 and at count 10 -> count unchanged, no error flags set.
REQ-037 clear asserted together with enter at count 12 with ovf_err = 1 -> next cycle count 0, EMPTY, ovf_err 0, digits 0/0.
REQ-038 reset pulsed low asynchronously (between edges) at count 7 -> outputs go to reset values immediately. An enter pulse on the first edge after release -> count 1.
